// File: rtl/button_conditioner_pkg.sv
// ----------------------------------------------------------------------------
// btn_cond_pkg
// Shared definitions for the pushbutton conditioner:
//   - btn_state_t : per-channel debounce FSM state encoding
//   - cnt_width() : width of the shared debounce/repeat counters, wide enough
//                   for the largest of the three cycle limits
// ----------------------------------------------------------------------------
package btn_cond_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        HELD         = 2'd2,
        RELEASE_PEND = 2'd3
    } btn_state_t;

    // Bits needed to hold max(debounce, delay, period) without wrapping.
    function automatic int cnt_width(input int debounce_cycles,
                                     input int repeat_delay,
                                     input int repeat_period);
        int max_v;
        max_v = debounce_cycles;
        max_v = (repeat_delay  > max_v) ? repeat_delay  : max_v;
        max_v = (repeat_period > max_v) ? repeat_period : max_v;
        return (max_v < 1) ? 1 : $clog2(max_v + 1);
    endfunction

endpackage

// File: rtl/button_conditioner_channel.sv
// ----------------------------------------------------------------------------
// btn_channel
// One pushbutton lane: 2-flop synchronizer, debounce FSM, debounce counter
// and auto-repeat counter. All outputs are registered.
// Ports:
//   clk         : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   btn_in      : raw asynchronous button input, active high
//   btn_level   : debounced level (1 in HELD / RELEASE_PEND)
//   btn_press   : one-cycle strobe on accepted press
//   btn_release : one-cycle strobe on accepted release
//   btn_repeat  : one-cycle auto-repeat strobe while held
// ----------------------------------------------------------------------------
module btn_channel
    import btn_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_repeat
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] DB_LIMIT = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] RD_LIMIT = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RP_LIMIT = CNT_W'(REPEAT_PERIOD);
    localparam bit               REPEAT_EN = (REPEAT_DELAY != 0);

    logic             sync0_r;
    logic             sync1_r;
    btn_state_t       state_r;
    btn_state_t       state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic [CNT_W-1:0] rcnt_r;
    logic [CNT_W-1:0] rcnt_s;
    logic [CNT_W-1:0] rcnt_inc_s;
    logic [CNT_W-1:0] rtarget_s;
    logic             rfirst_r;
    logic             rfirst_s;
    logic             level_r;
    logic             level_s;
    logic             press_r;
    logic             press_s;
    logic             release_r;
    logic             release_s;
    logic             repeat_r;
    logic             repeat_s;

    // Two-flop synchronizer; the FSM only ever looks at sync1_r.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0_r <= 1'b0;
            sync1_r <= 1'b0;
        end else begin
            sync0_r <= btn_in;
            sync1_r <= sync0_r;
        end
    end

    // Saturating increments and the current repeat target (delay, then period).
    always_comb begin
        cnt_inc_s  = (cnt_r  == CNT_MAX) ? cnt_r  : (cnt_r  + CNT_ONE);
        rcnt_inc_s = (rcnt_r == CNT_MAX) ? rcnt_r : (rcnt_r + CNT_ONE);
        rtarget_s  = rfirst_r ? RD_LIMIT : RP_LIMIT;
    end

    // Debounce FSM next state, counters and strobe requests.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        rcnt_s    = rcnt_r;
        rfirst_s  = rfirst_r;
        press_s   = 1'b0;
        release_s = 1'b0;
        repeat_s  = 1'b0;
        case (state_r)
            RELEASED: begin
                rcnt_s   = CNT_ZERO;
                rfirst_s = 1'b1;
                if (sync1_r) begin
                    state_s = PRESS_PEND;
                    cnt_s   = CNT_ONE;
                end else begin
                    cnt_s   = CNT_ZERO;
                end
            end
            PRESS_PEND: begin
                // Change is accepted on the DEBOUNCE_CYCLES-th consecutive high sample.
                if (!sync1_r) begin
                    state_s = RELEASED;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_inc_s == DB_LIMIT) begin
                    state_s  = HELD;
                    cnt_s    = CNT_ZERO;
                    rcnt_s   = CNT_ZERO;
                    rfirst_s = 1'b1;
                    press_s  = 1'b1;
                end else begin
                    cnt_s = cnt_inc_s;
                end
            end
            HELD: begin
                if (!sync1_r) begin
                    // Repeat counter holds its value while the release is pending.
                    state_s = RELEASE_PEND;
                    cnt_s   = CNT_ONE;
                end else if (REPEAT_EN && (rcnt_inc_s == rtarget_s)) begin
                    repeat_s = 1'b1;
                    rcnt_s   = CNT_ZERO;
                    rfirst_s = 1'b0;
                end else if (REPEAT_EN) begin
                    rcnt_s = rcnt_inc_s;
                end else begin
                    rcnt_s = CNT_ZERO;
                end
            end
            RELEASE_PEND: begin
                if (sync1_r) begin
                    // Bounce back: repeat timing resumes where it froze.
                    state_s = HELD;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_inc_s == DB_LIMIT) begin
                    state_s   = RELEASED;
                    cnt_s     = CNT_ZERO;
                    release_s = 1'b1;
                end else begin
                    cnt_s = cnt_inc_s;
                end
            end
            default: begin
                state_s  = RELEASED;
                cnt_s    = CNT_ZERO;
                rcnt_s   = CNT_ZERO;
                rfirst_s = 1'b1;
            end
        endcase
        level_s = (state_s == HELD) || (state_s == RELEASE_PEND);
    end

    // FSM, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= RELEASED;
            cnt_r     <= CNT_ZERO;
            rcnt_r    <= CNT_ZERO;
            rfirst_r  <= 1'b1;
            level_r   <= 1'b0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
            repeat_r  <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            rcnt_r    <= rcnt_s;
            rfirst_r  <= rfirst_s;
            level_r   <= level_s;
            press_r   <= press_s;
            release_r <= release_s;
            repeat_r  <= repeat_s;
        end
    end

    assign btn_level   = level_r;
    assign btn_press   = press_r;
    assign btn_release = release_r;
    assign btn_repeat  = repeat_r;

endmodule

// File: rtl/button_conditioner.sv
// ----------------------------------------------------------------------------
// button_conditioner
// Board-input front end: NUM_BTNS independent debounce channels turning raw
// bouncing pushbuttons into clean levels plus press/release/repeat strobes.
// Ports:
//   clk         : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   btn_in      : raw asynchronous button inputs, active high
//   btn_level   : debounced button state
//   btn_press   : one-cycle strobe on accepted 0->1
//   btn_release : one-cycle strobe on accepted 1->0
//   btn_repeat  : one-cycle auto-repeat strobe while held
// ----------------------------------------------------------------------------
module button_conditioner
    import btn_cond_pkg::*;
#(
    parameter int NUM_BTNS        = 5,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_BTNS-1:0] btn_in,
    output logic [NUM_BTNS-1:0] btn_level,
    output logic [NUM_BTNS-1:0] btn_press,
    output logic [NUM_BTNS-1:0] btn_release,
    output logic [NUM_BTNS-1:0] btn_repeat
);

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .btn_in      (btn_in[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i]),
            .btn_repeat  (btn_repeat[i])
        );
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Board-input front end that sits directly upstream of the register-file/ALU lab top. It turns raw, bouncing, asynchronous pushbutton inputs into clean signals: debounced levels plus single-cycle press, release and auto-repeat strobes. The top level consumes btn_press as its write strobe and btn_level as its mode selects, replacing ad-hoc synchronizer flops.

Parameters:
NUM_BTNS, 5, number of independent button channels (btnc, btnl, btnu, btnd, btnr).
DEBOUNCE_CYCLES, 500000, consecutive stable synchronized samples required to accept a change (5 ms at 100 MHz); must be ≥ 2.
REPEAT_DELAY, 50000000, cycles from the press strobe to the first repeat strobe; 0 disables auto-repeat.
REPEAT_PERIOD, 10000000, cycles between subsequent repeat strobes; must be ≥ 1 when REPEAT_DELAY ≠ 0.

Ports:
clk  input  1  system clock; all state on rising edge.
rst_n  input  1  asynchronous, active-low reset.
btn_in  input  NUM_BTNS  raw asynchronous button inputs, active high.
btn_level  output  NUM_BTNS  debounced button state.
btn_press  output  NUM_BTNS  one-cycle strobe on accepted 0→1.
btn_release  output  NUM_BTNS  one-cycle strobe on accepted 1→0.
btn_repeat  output  NUM_BTNS  one-cycle auto-repeat strobe while held.

Behaviour:
- Clock is clk. Reset is rst_n: asynchronous, active-low.
- Reset clears all state immediately, with no clock required. Every output is 0, synchronizer flops are 0, all channels are in RELEASED, and all counters are 0.
- Channels are fully independent. Simultaneous events on different channels produce strobes in the same cycles.
- Each bit passes through a 2-flop synchronizer (sync0 → sync1). The FSM samples only sync1.
- The per-channel FSM has four states: RELEASED, PRESS_PEND, HELD, RELEASE_PEND.
  - RELEASED: when sync1=1, go to PRESS_PEND with cnt=1.
  - PRESS_PEND: if sync1=0, return to RELEASED (bounce rejected, no strobe). Otherwise cnt increments. If sync1=1 and cnt=DEBOUNCE_CYCLES, go to HELD.
  - HELD: when sync1=0, go to RELEASE_PEND with cnt=1.
  - RELEASE_PEND: mirror of PRESS_PEND with polarity inverted. If sync1=1, return to HELD. If sync1=0 and cnt=DEBOUNCE_CYCLES, go to RELEASED.
- btn_level=1 in HELD and RELEASE_PEND; 0 otherwise.
- btn_press is registered: high for exactly the one cycle after the PRESS_PEND→HELD transition edge. btn_release is the same for RELEASE_PEND→RELEASED.
- Latency: suppose raw input is first sampled high at edge k and stays high. btn_level rises and btn_press pulses in the cycle following edge k+DEBOUNCE_CYCLES+1. Release latency is identical.
- Auto-repeat (only when REPEAT_DELAY ≠ 0):
  - Repeat counter clears on entry to HELD.
  - First btn_repeat pulse comes REPEAT_DELAY cycles after the btn_press cycle; subsequent pulses every REPEAT_PERIOD cycles.
  - The counter freezes in RELEASE_PEND and resumes if the channel bounces back to HELD.
  - The counter clears in RELEASED.
  - btn_repeat never coincides with btn_press.
- Counter width is $clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)+1). Counters saturate and never wrap.
- Reset released while a button is held: the channel starts in RELEASED, so a fresh btn_press occurs after the full debounce latency.

Decomposition:
- Package btn_cond_pkg holds:
  - enum typedef btn_state_t {RELEASED, PRESS_PEND, HELD, RELEASE_PEND};
  - the counter-width function.
- Sub-module btn_channel: single-bit synchronizer, FSM, debounce and repeat counters. It is instantiated NUM_BTNS times by a generate loop. The top only wires bus bits.

Test Plan:
(All scenarios use NUM_BTNS=5, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.)
1. Clean press: btn_in[0] goes 0→1 and is first sampled at edge 10, held → btn_press[0]=1 for the single cycle after edge 15; btn_level[0]=1 from then on; other bits stay 0.
2. Bounce rejection: btn_in[1] high for 3 edges, low 2, high 3, then low → btn_level[1], btn_press[1] and btn_release[1] stay 0 throughout.
3. Release: from HELD, btn_in[0]→0 first sampled at edge k → btn_release[0] pulses for one cycle after edge k+5 and btn_level[0] falls in the same cycle. A 2-cycle low glitch produces no strobe.
4. Auto-repeat: hold btn_in[2] with press pulse in cycle p → btn_repeat[2] high in cycles p+10, p+13, p+16, …; no repeat pulses after release is accepted.
5. Simultaneous: btn_in[0] and btn_in[4] rise on the same edge → both btn_press bits pulse in the same cycle. A later press on bit 3 does not disturb them.
6. Reset mid-debounce: rst_n low during PRESS_PEND → all outputs 0 asynchronously, before the next edge. rst_n high with btn_in[0] still 1 → btn_press[0] after full latency (edge k+5 relative to the first post-reset sample).
